uart_cmd_wrapper: RTL and testbench
===================================

// Module: uart_cmd_wrapper
// PURPOSE
//  Bluetooth-side command front end of MazeRunner. Contains a UART receiver and transmitter.
//  Receives two UART bytes from the remote (high byte first) and assembles them into a 16-bit
//  command for the command processor. Returns a one-byte response (e.g. 0xA5 pos-ack) to the
//  remote when the command processor asks for it.
// PARAMETERS
//  BAUD_DIV   434   clk cycles per UART bit (50 MHz / 115200); bench may override to 16
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  RX           in   1   UART serial in from remote (idle high, asynchronous to clk)
//  TX           out  1   UART serial out to remote (idle high)
//  clr_cmd_rdy  in   1   command processor has consumed cmd; clears cmd_rdy
//  send_resp    in   1   one-cycle pulse; transmit resp
//  resp         in   8   response byte; sampled on the send_resp cycle
//  cmd          out  16  assembled command {high byte, low byte}
//  cmd_rdy      out  1   cmd valid; held until cleared
//  resp_sent    out  1   response frame done; held until next accepted send_resp
// BEHAVIOUR
//  Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0. Rx/tx FSMs go to IDLE.
//   Wrapper FSM goes to HIGH. RX synchronizer flops preset to 1.
//  Reset asserted mid-frame aborts both frames. TX returns to 1 asynchronously.
//  Frame format: 8N1. Start bit 0, 8 data bits LSB first, stop bit 1. Baud counter is
//   $clog2(BAUD_DIV) bits wide.
//  Receiver:
//   - RX passes through a 2-flop synchronizer.
//   - States IDLE->RECV. A falling edge of the synchronized RX in IDLE enters RECV.
//   - The first sample point is at BAUD_DIV/2 (start bit). Later sample points are every
//     BAUD_DIV cycles: 9 more samples (8 data + stop).
//   - Start sample = 1 (glitch): return to IDLE, no byte.
//   - Stop sample = 0 (framing error): byte discarded, wrapper FSM forced to HIGH.
//   - Good stop: internal rx_rdy pulses 1 cycle after the stop sample.
//  Wrapper FSM:
//   - HIGH: on rx_rdy, latch the byte into high register and go to LOW.
//   - LOW: on rx_rdy, on the next clk edge set cmd={high,byte} and cmd_rdy=1, then go to HIGH.
//   - cmd only changes on that edge. It is stable while cmd_rdy=1 unless a new command completes.
//  cmd_rdy clearing:
//   - Cleared by clr_cmd_rdy.
//   - Also cleared when a start bit is detected while the wrapper is in HIGH (a new command
//     has begun).
//   - clr_cmd_rdy in the same cycle that a command completes: set wins, cmd_rdy stays 1.
//  Transmitter:
//   - States IDLE->XMIT.
//   - send_resp in IDLE loads {1,resp,0} into a 10-bit shift register and clears resp_sent.
//     TX drives the start bit on the next cycle.
//   - Each bit is held exactly BAUD_DIV cycles. A frame is 10*BAUD_DIV cycles.
//   - After the stop bit's last cycle: return to IDLE and set resp_sent=1. TX stays 1.
//   - send_resp during XMIT is ignored. The frame in flight is unaffected and resp_sent is not
//     cleared.
//  Rx and tx are fully independent. Full-duplex traffic must not corrupt either direction.
// TESTING
//  1. Bench transmitter sends bytes 0x20 then 0x00 -> cmd=16'h2000, cmd_rdy=1 within
//     BAUD_DIV+3 clks of the 2nd stop-bit centre. clr_cmd_rdy pulse -> cmd_rdy=0 next clk.
//  2. send_resp with resp=0xA5 -> TX pattern 0,1,0,1,0,0,1,0,1,1 with BAUD_DIV clks per bit.
//     resp_sent rises exactly 10*BAUD_DIV+1 clks after send_resp. Bench receiver reads 0xA5.
//  3. Pulse send_resp (resp=0x5A) mid-frame after 0xA5 -> only 0xA5 is transmitted, with no
//     second frame. resp_sent pulses once.
//  4. Send 0x40, then a corrupted frame with stop=0, then 0x60,0x01 -> cmd=16'h6001, never
//     16'h40xx.
//  5. Assert rst_n low for 1 clk during the 5th data bit of the high byte -> outputs at reset
//     values. The next clean pair 0x23,0xFF gives cmd=16'h23FF.
//  6. clr_cmd_rdy asserted on the exact cmd-completion cycle of 0x00,0x00 -> cmd_rdy=1.
//     1-cycle RX glitch (<BAUD_DIV/2) in IDLE -> no byte received.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// UART command front end: two received bytes (high first) form a 16-bit cmd; one-byte response is sent back on request.
// Latency: cmd_rdy 2 clks after the low byte's stop sample, TX start bit 1 clk after send_resp; no backpressure (send_resp while busy is dropped).
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        resp_sent
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
    typedef enum logic {WR_HIGH, WR_LOW}  wr_state_t;

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_baud_q, rx_baud_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_rdy_q, rx_rdy_d;
    logic            rx_ferr_q, rx_ferr_d;
    logic            rx_fall;
    logic            rx_start;

    // Preset to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall  = rx_prev_q & ~rx_sync_q;
    assign rx_start = (rx_state_q == RX_IDLE) && rx_fall;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_rdy_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_RECV;
                    rx_baud_d  = HALF_LAST;
                    rx_bit_d   = 4'd0;
                end
            end
            RX_RECV: begin
                if (rx_baud_q != '0) begin
                    rx_baud_d = rx_baud_q - BAUD_ONE;
                end else begin
                    rx_baud_d = BAUD_LAST;
                    rx_bit_d  = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd0) begin
                        // Start bit gone high again by mid-bit: treat as a glitch.
                        if (rx_sync_q) begin
                            rx_state_d = RX_IDLE;
                        end
                    end else if (rx_bit_q == 4'd9) begin
                        rx_state_d = RX_IDLE;
                        rx_rdy_d   = rx_sync_q;
                        rx_ferr_d  = ~rx_sync_q;
                    end else begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 8'h00;
            rx_rdy_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ---------------- command assembly ----------------
    wr_state_t wr_state_q, wr_state_d;
    logic [7:0]  high_q, high_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        cmd_done;

    always_comb begin
        wr_state_d = wr_state_q;
        high_d     = high_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        cmd_done   = 1'b0;
        if (rx_ferr_q) begin
            wr_state_d = WR_HIGH;
        end else if (rx_rdy_q) begin
            case (wr_state_q)
                WR_HIGH: begin
                    high_d     = rx_shift_q;
                    wr_state_d = WR_LOW;
                end
                WR_LOW: begin
                    cmd_d      = {high_q, rx_shift_q};
                    cmd_done   = 1'b1;
                    wr_state_d = WR_HIGH;
                end
                default: wr_state_d = WR_HIGH;
            endcase
        end
        // A completing command outranks a same-cycle clear.
        if (cmd_done) begin
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy || (rx_start && (wr_state_q == WR_HIGH))) begin
            cmd_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_HIGH;
            high_q     <= 8'h00;
            cmd_q      <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            high_q     <= high_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t     tx_state_q, tx_state_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic          resp_sent_q, resp_sent_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_state_d  = TX_XMIT;
                    tx_shift_d  = {1'b1, resp, 1'b0};
                    tx_baud_d   = '0;
                    tx_bit_d    = 4'd0;
                    resp_sent_d = 1'b0;
                end
            end
            TX_XMIT: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    // Ones shift in behind the frame, so the line idles high afterwards.
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d  = TX_IDLE;
                        resp_sent_d = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_ONE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= 10'h3FF;
            tx_baud_q   <= '0;
            tx_bit_q    <= 4'd0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = tx_shift_q[0];
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: directed UART traffic both ways, a frame-level model checked every cycle,
// plus literal expectations for the headline commands and the response waveform.
module tb_uart_cmd_wrapper;

    localparam int B = 16;
    localparam int H = B / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        resp_sent;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.BAUD_DIV(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp  (send_resp),
        .resp       (resp),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .resp_sent  (resp_sent)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response side of the model: one frame of 10 bits, each B clocks, after an accepted request.
    logic       m_busy = 1'b0;
    logic [9:0] m_frame = 10'h3FF;
    int         m_cyc = 0;
    logic       m_resp_sent = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy      <= 1'b0;
            m_resp_sent <= 1'b0;
        end else if (m_busy) begin
            if (m_cyc == 10 * B - 1) begin
                m_busy      <= 1'b0;
                m_resp_sent <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end else if (send_resp) begin
            m_busy      <= 1'b1;
            m_frame     <= {1'b1, resp, 1'b0};
            m_cyc       <= 0;
            m_resp_sent <= 1'b0;
        end
    end

    // Command side of the model: byte pairing, updated by the sender as frames go out.
    logic [15:0] m_cmd = 16'h0000;
    logic [15:0] m_next = 16'h0000;
    logic        m_win = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    logic        m_hi_vld = 1'b0;
    logic        mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("tx_line", TX, m_busy ? m_frame[m_cyc / B] : 1'b1);
            check("resp_sent", resp_sent, m_resp_sent);
            if (!m_win) check("cmd_hold", cmd, m_cmd);
            else        check("cmd_window", (cmd === m_cmd) || (cmd === m_next), 1);
        end
    end

    int   rs_rises = 0;
    logic rs_prev = 1'b0;
    always @(negedge clk) begin
        if (!rs_prev && resp_sent === 1'b1) rs_rises++;
        rs_prev = resp_sent;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [9:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            RX = f[i];
            tick(B);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic hold_clr);
        logic [9:0] f;
        int n;
        f = {stop, b, 1'b0};
        if (!stop) begin
            drive_bits(f, 10);
            RX = 1'b1;
            tick(B);
            m_hi_vld = 1'b0;
        end else if (!m_hi_vld) begin
            drive_bits(f, 10);
            m_hi = b;
            m_hi_vld = 1'b1;
            check("rdy_cleared_by_start", cmd_rdy, 0);
        end else begin
            m_next = {m_hi, b};
            m_hi_vld = 1'b0;
            drive_bits(f, 9);
            RX = 1'b1;
            clr_cmd_rdy = hold_clr;
            m_win = 1'b1;
            n = 0;
            while (!(cmd_rdy === 1'b1 && cmd === m_next) && n < H + B + 3) begin
                tick(1);
                n++;
            end
            clr_cmd_rdy = 1'b0;
            check("cmd_done_in_time", (cmd_rdy === 1'b1) && (cmd === m_next), 1);
            m_cmd = m_next;
            m_win = 1'b0;
            if (n < B) tick(B - n);
        end
    endtask

    task automatic recv_tx(output logic [7:0] b, output logic ok);
        int n;
        n = 0;
        ok = 1'b1;
        b = 8'h00;
        while (TX !== 1'b0 && n < 4 * B) begin
            tick(1);
            n++;
        end
        if (TX !== 1'b0) ok = 1'b0;
        tick(H);
        if (TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(B);
            b[i] = TX;
        end
        tick(B);
        if (TX !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] pat;
        logic [7:0] rb;
        logic       rok;
        int         t;
        int         rises0;

        // Reset values
        #2 rst_n = 1'b0;
        tick(2);
        check("rst_tx", TX, 1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_resp_sent", resp_sent, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick(3);

        // 1: basic command and clear
        send_byte(8'h20, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        check("t1_cmd", cmd, 16'h2000);
        check("t1_rdy", cmd_rdy, 1);
        tick(3);
        check("t1_rdy_held", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("t1_rdy_clr", cmd_rdy, 0);

        // 2+3: response 0xA5 with a second request dropped mid-frame
        rises0 = rs_rises;
        pat = 10'h000;
        resp = 8'hA5;
        send_resp = 1'b1;
        fork
            begin
                t = 0;
                while (resp_sent !== 1'b1 && t < 12 * B) begin
                    tick(1);
                    t++;
                end
                check("t2_resp_sent_latency", t, 10 * B + 1);
            end
            begin
                tick(1);
                send_resp = 1'b0;
                tick(H);
                pat[0] = TX;
                for (int k = 1; k < 10; k++) begin
                    tick(B);
                    pat[k] = TX;
                end
            end
            begin
                tick(5 * B);
                resp = 8'h5A;
                send_resp = 1'b1;
                tick(1);
                send_resp = 1'b0;
            end
        join
        check("t2_tx_pattern", pat, 10'b1101001010);
        check("t2_rx_byte", pat[8:1], 8'hA5);
        tick(12 * B);
        check("t3_single_resp", rs_rises - rises0, 1);
        check("t3_tx_idle", TX, 1);

        // 4: framing error drops the pending high byte
        send_byte(8'h40, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h60, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        check("t4_cmd", cmd, 16'h6001);
        check("t4_rdy", cmd_rdy, 1);

        // 5: reset mid-frame in both directions
        resp = 8'h00;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        drive_bits({1'b1, 8'h7E, 1'b0}, 5);
        RX = 1'b1;
        tick(H);
        check("t5_tx_busy", TX, 0);
        rst_n = 1'b0;
        RX = 1'b1;
        m_cmd = 16'h0000;
        m_hi_vld = 1'b0;
        m_win = 1'b0;
        #1;
        check("t5_tx_async", TX, 1);
        check("t5_cmd", cmd, 16'h0000);
        check("t5_rdy", cmd_rdy, 0);
        check("t5_resp_sent", resp_sent, 0);
        tick(1);
        rst_n = 1'b1;
        tick(20 * B);
        send_byte(8'h23, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        check("t5_cmd_after", cmd, 16'h23FF);

        // 6: set beats clear, glitch rejection, full duplex
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b1);
        check("t6_cmd", cmd, 16'h0000);
        tick(2);
        check("t6_rdy_set_wins", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("t6_rdy_clr", cmd_rdy, 0);
        RX = 1'b0;
        tick(1);
        RX = 1'b1;
        tick(3 * B);
        fork
            begin
                send_byte(8'h12, 1'b1, 1'b0);
                send_byte(8'h34, 1'b1, 1'b0);
            end
            begin
                tick(B);
                resp = 8'h3C;
                send_resp = 1'b1;
                tick(1);
                send_resp = 1'b0;
                recv_tx(rb, rok);
            end
        join
        check("t6_cmd_after_glitch", cmd, 16'h1234);
        check("t6_duplex_frame_ok", rok, 1);
        check("t6_duplex_byte", rb, 8'h3C);
        tick(4 * B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
